// File: rtl/axis_mux_2_arbiter_pkg.sv
// rtl/axis_mux_2_arbiter_pkg.sv - shared state encoding, port indices and grant helper
package axis_mux_2_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2
    } arb_state_t;

    localparam logic PORT_0 = 1'b0;
    localparam logic PORT_1 = 1'b1;

    function automatic logic [1:0] onehot_grant(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/axis_mux_2_arbiter_arb_select_2.sv
// rtl/axis_mux_2_arbiter_arb_select_2.sv - two-way winner pick, round-robin or fixed priority
module arb_select_2
    import axis_mux_2_arbiter_pkg::*;
(
    input  logic [1:0] request,
    input  logic       last_grant,
    input  logic       round_robin,
    input  logic       lsb_priority,
    output logic       winner,
    output logic       valid
);

    always_comb begin
        valid  = |request;
        winner = PORT_0;
        case (request)
            2'b01:   winner = PORT_0;
            2'b10:   winner = PORT_1;
            // Tie: round-robin hands the port to whoever did not own it last.
            2'b11:   winner = round_robin ? ~last_grant : (lsb_priority ? PORT_0 : PORT_1);
            default: winner = PORT_0;
        endcase
    end

endmodule

// File: rtl/axis_mux_2_arbiter.sv
// rtl/axis_mux_2_arbiter.sv - sequences enable/select of a 2-port stream mux, one frame per grant
module axis_mux_2_arbiter
    import axis_mux_2_arbiter_pkg::*;
#(
    parameter int ARB_ROUND_ROBIN  = 1,
    parameter int ARB_LSB_PRIORITY = 1,
    parameter int MAX_BURST        = 1,
    parameter int TIMEOUT_CYCLES   = 0,
    parameter int COUNT_WIDTH      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   request_0,
    input  logic                   request_1,
    input  logic                   mon_tvalid,
    input  logic                   mon_tready,
    input  logic                   mon_tlast,
    input  logic                   arb_enable,
    input  logic                   count_clr,
    output logic                   mux_enable,
    output logic                   mux_select,
    output logic                   busy,
    output logic [1:0]             grant,
    output logic [COUNT_WIDTH-1:0] frame_count_0,
    output logic [COUNT_WIDTH-1:0] frame_count_1,
    output logic                   stall
);

    localparam int   BURST_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int   WD_W       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic RESET_LAST = (ARB_LSB_PRIORITY != 0) ? PORT_1 : PORT_0;

    arb_state_t         state_q, state_d;
    logic               sel_d;
    logic               last_q, last_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               winner, win_valid;
    logic               frame_end;
    logic               burst_more;
    logic               owner_request;

    assign frame_end     = mon_tvalid & mon_tready & mon_tlast;
    assign burst_more    = (32'(burst_q) + 32'd1) < 32'(MAX_BURST);
    assign owner_request = mux_select ? request_1 : request_0;
    assign busy          = (state_q != ST_IDLE);

    arb_select_2 u_arb_select_2 (
        .request      ({request_1, request_0}),
        .last_grant   (last_q),
        .round_robin  (ARB_ROUND_ROBIN != 0),
        .lsb_priority (ARB_LSB_PRIORITY != 0),
        .winner       (winner),
        .valid        (win_valid)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = mux_select;
        last_d  = last_q;
        burst_d = burst_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_enable && win_valid) begin
                    state_d = ST_GRANT;
                    sel_d   = winner;
                end
            end
            // One enable cycle is enough: the mux latches the port and holds it to tlast.
            ST_GRANT: state_d = ST_BUSY;
            ST_BUSY: begin
                if (frame_end) begin
                    if (burst_more && arb_enable && owner_request) begin
                        state_d = ST_GRANT;
                        burst_d = burst_q + BURST_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                        last_d  = mux_select;
                        burst_d = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mux_select <= PORT_0;
            last_q     <= RESET_LAST;
            burst_q    <= '0;
            mux_enable <= 1'b0;
            grant      <= 2'b00;
        end else begin
            state_q    <= state_d;
            mux_select <= sel_d;
            last_q     <= last_d;
            burst_q    <= burst_d;
            mux_enable <= (state_d == ST_GRANT);
            grant      <= (state_d == ST_IDLE) ? 2'b00 : onehot_grant(sel_d);
        end
    end

    // Clear wins over a coincident frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_count_0 <= '0;
            frame_count_1 <= '0;
        end else if (count_clr) begin
            frame_count_0 <= '0;
            frame_count_1 <= '0;
        end else if (state_q == ST_BUSY && frame_end) begin
            if (mux_select)
                frame_count_1 <= frame_count_1 + COUNT_WIDTH'(1);
            else
                frame_count_0 <= frame_count_0 + COUNT_WIDTH'(1);
        end
    end

    if (TIMEOUT_CYCLES > 0) begin : g_watchdog
        logic [WD_W-1:0] wd_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wd_q  <= '0;
                stall <= 1'b0;
            end else begin
                stall <= 1'b0;
                if (state_q != ST_BUSY || (mon_tvalid && mon_tready)) begin
                    wd_q <= '0;
                end else if (wd_q != WD_W'(TIMEOUT_CYCLES)) begin
                    wd_q  <= wd_q + WD_W'(1);
                    stall <= (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
                end
            end
        end
    end else begin : g_no_watchdog
        assign stall = 1'b0;
    end

endmodule

// File: tb/tb_axis_mux_2_arbiter.sv
// tb/tb_axis_mux_2_arbiter.sv - three arbiter configurations against a frame-level reference model
module tb_axis_mux_2_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int req_pct [2];
    int valid_pct, ready_pct, clr_pct, len_fix, limit;
    bit glob_aen, clr_on_end;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int RR = (g == 1) ? 0 : 1;
        localparam int MB = (g == 2) ? 3 : 1;
        localparam int TO = (g == 0) ? 8 : 0;
        localparam int CW = (g == 1) ? 3 : 16;

        logic          req0, req1, mtv, mtr, mtl, aen, clr;
        logic          men, msel, bsy, stl;
        logic [1:0]    gnt;
        logic [CW-1:0] fc0, fc1;

        bit has [2];
        int len [2];
        bit active, en_seen, sel_seen;
        int src, left;
        int m_owner, m_en, m_burst, m_last, m_quiet, m_stall;
        int m_cnt [2];
        int cyc, first_en_cyc, first_en_sel, nlog, glog_code, stall_cnt;

        axis_mux_2_arbiter #(
            .ARB_ROUND_ROBIN  (RR),
            .ARB_LSB_PRIORITY (1),
            .MAX_BURST        (MB),
            .TIMEOUT_CYCLES   (TO),
            .COUNT_WIDTH      (CW)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .request_0     (req0),
            .request_1     (req1),
            .mon_tvalid    (mtv),
            .mon_tready    (mtr),
            .mon_tlast     (mtl),
            .arb_enable    (aen),
            .count_clr     (clr),
            .mux_enable    (men),
            .mux_select    (msel),
            .busy          (bsy),
            .grant         (gnt),
            .frame_count_0 (fc0),
            .frame_count_1 (fc1),
            .stall         (stl)
        );

        function automatic int pick(input bit r0, input bit r1, input int last);
            if (r0 && r1) return (RR != 0) ? 1 - last : 0;
            return r1 ? 1 : 0;
        endfunction

        // m_owner = -1 means nobody holds the mux; m_en marks the enable cycle of a grant.
        task automatic model_reset();
            m_owner = -1; m_en = 0; m_burst = 0; m_last = 1;
            m_quiet = 0; m_stall = 0; m_cnt[0] = 0; m_cnt[1] = 0;
        endtask

        task automatic model_step();
            bit beat, fend;
            int stall_n;
            int rq [2];
            beat = mtv && mtr; fend = beat && mtl; stall_n = 0;
            rq[0] = req0; rq[1] = req1;
            if (m_owner < 0) begin
                m_quiet = 0;
                if (aen && (req0 || req1)) begin
                    m_owner = pick(req0, req1, m_last); m_en = 1; m_burst = 0;
                end
            end else if (m_en != 0) begin
                m_en = 0; m_quiet = 0;
            end else begin
                if (beat) m_quiet = 0;
                else if (TO > 0 && m_quiet < TO) begin
                    m_quiet++;
                    if (m_quiet == TO) stall_n = 1;
                end
                if (fend) begin
                    m_cnt[m_owner] = (m_cnt[m_owner] + 1) % (1 << CW);
                    m_burst++;
                    if (m_burst < MB && aen && rq[m_owner] != 0) m_en = 1;
                    else begin m_last = m_owner; m_owner = -1; m_burst = 0; end
                end
            end
            if (clr) begin m_cnt[0] = 0; m_cnt[1] = 0; end
            m_stall = stall_n;
        endtask

        initial begin
            req0 = 0; req1 = 0; mtv = 0; mtr = 0; mtl = 0; aen = 0; clr = 0;
            has[0] = 0; has[1] = 0; len[0] = 1; len[1] = 1;
            active = 0; en_seen = 0; sel_seen = 0; src = 0; left = 0;
            model_reset();
            cyc = 0; first_en_cyc = -1; first_en_sel = -1; nlog = 0; glog_code = 0; stall_cnt = 0;
            forever begin
                @(posedge clk);
                if (rst) begin
                    model_reset();
                    active = 0; has[0] = 0; has[1] = 0; en_seen = 0;
                    cyc = 0; first_en_cyc = -1; first_en_sel = -1;
                    nlog = 0; glog_code = 0; stall_cnt = 0;
                end else begin
                    cyc++;
                    model_step();
                    if (active && mtv && mtr) begin
                        left--;
                        if (left == 0) begin active = 0; has[src] = 0; end
                    end
                    if (en_seen) begin
                        if (!has[sel_seen]) begin
                            has[sel_seen] = 1;
                            len[sel_seen] = (len_fix > 0) ? len_fix : int'($urandom_range(5, 1));
                        end
                        active = 1; src = sel_seen; left = len[src];
                    end
                end
                #1;
                for (int p = 0; p < 2; p++) begin
                    if (!has[p] && int'($urandom_range(99)) < req_pct[p]) begin
                        has[p] = 1;
                        len[p] = (len_fix > 0) ? len_fix : int'($urandom_range(5, 1));
                    end
                end
                req0 = has[0];
                req1 = has[1];
                mtv  = active && (int'($urandom_range(99)) < valid_pct);
                mtr  = int'($urandom_range(99)) < ready_pct;
                mtl  = active && (left == 1);
                aen  = glob_aen && !(limit > 0 && nlog >= limit);
                clr  = clr_on_end ? (mtv && mtr && mtl) : (int'($urandom_range(99)) < clr_pct);
                @(negedge clk);
                if (rst) model_reset();
                check($sformatf("i%0d_mux_enable", g), men, m_en);
                check($sformatf("i%0d_busy", g), bsy, (m_owner >= 0) ? 1 : 0);
                check($sformatf("i%0d_grant", g), gnt, (m_owner < 0) ? 0 : (m_owner == 0 ? 1 : 2));
                if (m_owner >= 0) check($sformatf("i%0d_mux_select", g), msel, m_owner);
                check($sformatf("i%0d_frame_count_0", g), fc0, m_cnt[0]);
                check($sformatf("i%0d_frame_count_1", g), fc1, m_cnt[1]);
                check($sformatf("i%0d_stall", g), stl, m_stall);
                en_seen  = men;
                sel_seen = msel;
                if (men && !rst) begin
                    if (first_en_cyc < 0) begin first_en_cyc = cyc; first_en_sel = int'(msel); end
                    if (nlog < 31) glog_code |= int'(msel) << nlog;
                    nlog++;
                end
                if (stl) stall_cnt++;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    initial begin
        // Single requester, 4-beat frame, one grant only.
        req_pct = '{100, 0}; len_fix = 4; valid_pct = 100; ready_pct = 100;
        clr_pct = 0; clr_on_end = 0; limit = 1; glob_aen = 1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        run(20);
        check("a_first_enable_cycle", cfg[0].first_en_cyc, 1);
        check("a_first_select", cfg[0].first_en_sel, 0);
        check("a_frame_count_0", cfg[0].fc0, 1);
        check("a_frame_count_1", cfg[0].fc1, 0);
        check("a_busy_after", cfg[0].bsy, 0);
        check("a_grant_after", cfg[0].gnt, 0);

        // Both requesting, 3-beat frames, five grants.
        req_pct = '{100, 100}; len_fix = 3; limit = 5;
        do_reset();
        run(60);
        check("b_rr_grants", cfg[0].nlog, 5);
        check("b_rr_order", cfg[0].glog_code, 10);
        check("b_rr_count_0", cfg[0].fc0, 3);
        check("b_rr_count_1", cfg[0].fc1, 2);
        check("b_fixed_order", cfg[1].glog_code, 0);
        check("b_fixed_count_0", cfg[1].fc0, 5);
        check("b_fixed_count_1", cfg[1].fc1, 0);
        check("b_burst_order", cfg[2].glog_code, 24);
        check("b_burst_count_0", cfg[2].fc0, 3);
        check("b_burst_count_1", cfg[2].fc1, 2);

        // Port 0 stops requesting: fixed priority finally serves port 1.
        req_pct = '{0, 100}; limit = 0;
        run(40);
        check("b2_fixed_after_drop", (cfg[1].glog_code >> 5) & 3, 2);

        // Output stalled in BUSY: one watchdog pulse, then the frame completes.
        req_pct = '{100, 0}; len_fix = 2; ready_pct = 0; limit = 1;
        do_reset();
        run(25);
        check("c_stall_pulses", cfg[0].stall_cnt, 1);
        check("c_still_busy", cfg[0].bsy, 1);
        ready_pct = 100;
        run(10);
        check("c_frame_done", cfg[0].fc0, 1);
        check("c_idle_after", cfg[0].bsy, 0);
        check("c_stall_total", cfg[0].stall_cnt, 1);

        // Clear coincident with every frame end; arb_enable drops after the third grant.
        req_pct = '{100, 100}; len_fix = 3; ready_pct = 100; clr_on_end = 1; limit = 3;
        do_reset();
        run(40);
        check("d_grants", cfg[0].nlog, 3);
        check("d_count_0", cfg[0].fc0, 0);
        check("d_count_1", cfg[0].fc1, 0);
        check("d_idle", cfg[0].bsy, 0);

        clr_on_end = 0; limit = 0; len_fix = 0;
        for (int r = 0; r < 40; r++) begin
            req_pct[0] = int'($urandom_range(100));
            req_pct[1] = int'($urandom_range(100));
            valid_pct  = int'($urandom_range(100, 30));
            ready_pct  = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(100, 20));
            clr_pct    = int'($urandom_range(3));
            glob_aen   = ($urandom_range(9) != 0);
            if ($urandom_range(7) == 0) do_reset();
            run(100);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
